// File: rtl/sys_ctrl_v2.sv
// sys_ctrl_v2: byte-framed command controller driving a register file, an ALU and a TX FIFO.
// Optional SYS_CTRL_TIMEOUT_EN aborts a frame stuck in a waiting state for TO_CYC cycles.
module sys_ctrl_v2 #(
   parameter int DW     = 8,
   parameter int AW     = 4,
   parameter int FW     = 4,
   parameter int RB     = 2,
   parameter int TO_CYC = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    rx_data,
   input  logic             rx_valid,
   input  logic [DW-1:0]    rf_rd_data,
   input  logic             rf_rd_valid,
   input  logic [RB*DW-1:0] alu_out,
   input  logic             alu_valid,
   input  logic             fifo_full,
   output logic [AW-1:0]    rf_addr,
   output logic             rf_wr_en,
   output logic             rf_rd_en,
   output logic [DW-1:0]    rf_wr_data,
   output logic             alu_en,
   output logic [FW-1:0]    alu_fun,
   output logic             clk_gate_en,
   output logic             fifo_wr_en,
   output logic [DW-1:0]    fifo_wr_data,
   output logic             clk_div_en,
   output logic             busy,
   output logic             err
);
   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT,
      OP_A, OP_A_WR, OP_B, OP_B_WR, FUN, ALU_WAIT, TX
   } state_t;
   localparam int KW = $clog2(RB + 1);
   state_t            state;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     data;
   logic [FW-1:0]     fun;
   logic [RB*DW-1:0]  res;
   logic [KW-1:0]     len, k;
   logic              to;
`ifdef SYS_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYC + 1);
   logic [TW-1:0] tcnt;
   logic          timed, leave;
   always_comb begin
      timed = state inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT};
      leave = state == RD_WAIT ? rf_rd_valid : state == ALU_WAIT ? alu_valid : rx_valid;
      to    = timed && !leave && tcnt == TW'(TO_CYC - 1);
   end
`else
   assign to = 1'b0;
`endif
   assign rf_addr      = state == OP_A_WR ? '0 : state == OP_B_WR ? AW'(1) : addr;
   assign rf_wr_en     = state inside {WR_EXEC, OP_A_WR, OP_B_WR};
   assign rf_rd_en     = state == RD_EXEC;
   assign rf_wr_data   = data;
   assign alu_en       = state == ALU_WAIT;
   assign clk_gate_en  = state == ALU_WAIT;
   assign alu_fun      = fun;
   assign fifo_wr_en   = state == TX && !fifo_full;
   assign fifo_wr_data = res[DW*k +: DW];
   assign clk_div_en   = 1'b1;
   assign busy         = state != IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         addr  <= '0;
         data  <= '0;
         fun   <= '0;
         res   <= '0;
         len   <= '0;
         k     <= '0;
         err   <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
         tcnt  <= '0;
`endif
      end else begin
         err <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
         tcnt <= (timed && !leave && !to) ? tcnt + 1'b1 : '0;
`endif
         if (to) begin
            state <= IDLE;
            err   <= 1'b1;
         end else
            case (state)
               IDLE: if (rx_valid)
                  case (rx_data)
                     DW'('hAA): state <= WR_ADDR;
                     DW'('hBB): state <= RD_ADDR;
                     DW'('hCC): state <= OP_A;
                     DW'('hDD): state <= FUN;
                     default:   err   <= 1'b1;
                  endcase
               WR_ADDR: if (rx_valid) begin
                  addr  <= rx_data[AW-1:0];
                  state <= WR_DATA;
               end
               WR_DATA: if (rx_valid) begin
                  data  <= rx_data;
                  state <= WR_EXEC;
               end
               WR_EXEC: state <= IDLE;
               RD_ADDR: if (rx_valid) begin
                  addr  <= rx_data[AW-1:0];
                  state <= RD_EXEC;
               end
               RD_EXEC: state <= RD_WAIT;
               RD_WAIT: if (rf_rd_valid) begin
                  res   <= (RB*DW)'(rf_rd_data);
                  len   <= KW'(1);
                  k     <= '0;
                  state <= TX;
               end
               OP_A: if (rx_valid) begin
                  data  <= rx_data;
                  state <= OP_A_WR;
               end
               OP_A_WR: state <= OP_B;
               OP_B: if (rx_valid) begin
                  data  <= rx_data;
                  state <= OP_B_WR;
               end
               OP_B_WR: state <= FUN;
               FUN: if (rx_valid) begin
                  fun   <= rx_data[FW-1:0];
                  state <= ALU_WAIT;
               end
               ALU_WAIT: if (alu_valid) begin
                  res   <= alu_out;
                  len   <= KW'(RB);
                  k     <= '0;
                  state <= TX;
               end
               TX: if (!fifo_full) begin
                  k     <= k == len - 1'b1 ? '0 : k + 1'b1;
                  state <= k == len - 1'b1 ? IDLE : TX;
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_sys_ctrl_v2.sv
// tb_sys_ctrl_v2: frame-level scoreboard bench for sys_ctrl_v2 with randomized frames and responders.
module tb_sys_ctrl_v2;
   localparam int DW = 8, AW = 4, FW = 4, RB = 2, TO = 15;
   logic clk = 1'b0, rst = 1'b0;
   logic [DW-1:0] rx_data = '0, rf_rd_data = '0;
   logic rx_valid = 1'b0, rf_rd_valid = 1'b0, alu_valid = 1'b0, fifo_full = 1'b0;
   logic [RB*DW-1:0] alu_out = '0;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wr_data, fifo_wr_data;
   logic [FW-1:0] alu_fun;
   logic rf_wr_en, rf_rd_en, alu_en, clk_gate_en, fifo_wr_en, clk_div_en, busy, err;

   sys_ctrl_v2 #(.DW(DW), .AW(AW), .FW(FW), .RB(RB), .TO_CYC(TO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_out(alu_out), .alu_valid(alu_valid),
      .fifo_full(fifo_full), .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
      .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .clk_div_en(clk_div_en),
      .busy(busy), .err(err));

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   int exp_wr[$], exp_rd[$], exp_tx[$];
   int wr_log[$], rd_log[$], tx_log[$], tx_cyc[$];
   int exp_fun = 0, exp_err = 0, err_cnt = 0, alu_cnt = 0, last_fun = 0;
   int gap = 0, rd_dly = 0, rd_dat = -1, alu_dly = 0, alu_fix = -1;
   int ff_from = 0, ff_until = 0;
   bit ff_rand = 0, rd_mute = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      fifo_full = (cyc >= ff_from && cyc < ff_until) || (ff_rand && $urandom_range(0, 3) == 0);

   initial forever begin
      @(negedge clk);
      if (rst && rf_rd_en && !rd_mute) begin
         int d, v;
         d = rd_dly > 0 ? rd_dly : int'($urandom_range(1, 5));
         v = rd_dat >= 0 ? rd_dat : int'($urandom_range(0, 255));
         repeat (d) @(negedge clk);
         rf_rd_data = v[7:0];
         rf_rd_valid = 1'b1;
         exp_tx.push_back(v);
         @(negedge clk);
         rf_rd_valid = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst && alu_en) begin
         int d, v;
         d = alu_dly > 0 ? alu_dly : int'($urandom_range(1, 5));
         v = alu_fix >= 0 ? alu_fix : int'($urandom_range(0, 65535));
         repeat (d) @(negedge clk);
         alu_out = v[15:0];
         alu_valid = 1'b1;
         exp_tx.push_back(v & 255);
         exp_tx.push_back((v >> 8) & 255);
         @(negedge clk);
         alu_valid = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      #2;
      if (rst) begin
         if (err) err_cnt++;
         if (rf_wr_en) begin
            wr_log.push_back({rf_addr, rf_wr_data});
            if (exp_wr.size() == 0) chk("wr_unexpected", {rf_addr, rf_wr_data}, 32'hFFFF_FFFF);
            else chk("wr", {rf_addr, rf_wr_data}, exp_wr.pop_front());
         end
         if (rf_rd_en) begin
            rd_log.push_back(rf_addr);
            if (exp_rd.size() == 0) chk("rd_unexpected", rf_addr, 32'hFFFF_FFFF);
            else chk("rd_addr", rf_addr, exp_rd.pop_front());
         end
         if (fifo_wr_en) begin
            chk("fifo_wr_while_full", fifo_full, 0);
            tx_log.push_back(fifo_wr_data);
            tx_cyc.push_back(cyc);
            if (exp_tx.size() == 0) chk("tx_unexpected", fifo_wr_data, 32'hFFFF_FFFF);
            else chk("tx_byte", fifo_wr_data, exp_tx.pop_front());
         end
         if (alu_en) begin
            alu_cnt++;
            last_fun = alu_fun;
            chk("clk_gate_en", clk_gate_en, 1);
            chk("alu_fun", alu_fun, exp_fun);
         end else if (clk_gate_en) chk("gate_without_alu", clk_gate_en, 0);
      end
   end

   task automatic send(input int b);
      repeat ($urandom_range(0, gap)) @(negedge clk);
      @(negedge clk);
      rx_data = b[7:0];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic junk(input int b);
      int n = 0;
      while (!alu_en && n < 10) begin @(negedge clk); n++; end
      if (alu_en) begin
         rx_data = b[7:0];
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin @(negedge clk); n++; end
      chk("frame_done_busy", busy, 0);
   endtask

   task automatic fr_wr(input int a, input int d);
      exp_wr.push_back(((a & 15) << 8) | (d & 255));
      send('hAA); send(a); send(d);
   endtask

   task automatic fr_rd(input int a);
      exp_rd.push_back(a & 15);
      send('hBB); send(a);
   endtask

   task automatic fr_alu(input int a, input int b, input int f, input int j);
      exp_wr.push_back(a & 255);
      exp_wr.push_back(256 | (b & 255));
      exp_fun = f & 15;
      send('hCC); send(a); send(b); send(f); junk(j);
   endtask

   task automatic fr_dd(input int f, input int j);
      exp_fun = f & 15;
      send('hDD); send(f); junk(j);
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_ctl"}, {busy, rf_wr_en, rf_rd_en, alu_en, clk_gate_en, fifo_wr_en, err, clk_div_en}, 8'h01);
      chk({nm, "_dat"}, {rf_addr, rf_wr_data, alu_fun, fifo_wr_data}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, e0, op, t;
      repeat (2) @(negedge clk);
      #1 chk_rst("reset");
      @(negedge clk) rst = 1'b1;

      fr_wr(5, 'h3C);
      wait_idle(20);
      chk("w34_count", wr_log.size(), 1);
      if (wr_log.size() > 0) chk("w34_word", wr_log[0], 'h53C);

      rd_dly = 3; rd_dat = 'h5A;
      fr_rd(7);
      c = cyc;
      chk("r35_rd_en", rf_rd_en, 1);
      ff_from = c + 4; ff_until = c + 8;
      wait_idle(40);
      chk("r35_rd_count", rd_log.size(), 1);
      chk("r35_tx_count", tx_log.size(), 1);
      if (tx_log.size() > 0) begin
         chk("r35_tx_byte", tx_log[0], 'h5A);
         chk("r35_tx_cycle", tx_cyc[0] - c, 8);
      end
      rd_dly = 0; rd_dat = -1;

      wr_log.delete(); tx_log.delete(); alu_cnt = 0;
      alu_dly = 4; alu_fix = 'h0046;
      fr_alu('h12, 'h34, 0, 'h00);
      wait_idle(40);
      chk("a36_wr_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         chk("a36_wr_a", wr_log[0], 'h012);
         chk("a36_wr_b", wr_log[1], 'h134);
      end
      chk("a36_alu_cycles", alu_cnt, 5);
      chk("a36_tx_count", tx_log.size(), 2);
      if (tx_log.size() == 2) begin
         chk("a36_tx0", tx_log[0], 'h46);
         chk("a36_tx1", tx_log[1], 'h00);
      end

      tx_log.delete();
      alu_fix = 'hABCD;
      fr_dd(3, 'hAA);
      wait_idle(40);
      chk("d37_fun", last_fun, 3);
      chk("d37_tx_count", tx_log.size(), 2);
      if (tx_log.size() == 2) begin
         chk("d37_tx0", tx_log[0], 'hCD);
         chk("d37_tx1", tx_log[1], 'hAB);
      end
      repeat (5) @(negedge clk);
      chk("d37_junk_ignored", busy, 0);
      alu_dly = 0; alu_fix = -1;

      e0 = err_cnt;
      exp_err++;
      send('h55);
      #1 chk("b38_err", err, 1);
      chk("b38_busy", busy, 0);
      @(negedge clk) #1 chk("b38_err_pulse", err, 0);
      chk("b38_err_count", err_cnt - e0, 1);

      wr_log.delete();
      exp_wr.push_back('h012);
      send('hCC); send('h12);
      @(negedge clk) rst = 1'b0;
      #1 chk_rst("midframe_reset");
      @(negedge clk) rst = 1'b1;
      fr_wr(9, 'hE7);
      wait_idle(20);
      chk("x38_wr_count", wr_log.size(), 2);
      if (wr_log.size() == 2) chk("x38_after_reset", wr_log[1], 'h9E7);

      gap = 2; ff_rand = 1;
      for (int i = 0; i < 60; i++) begin
         t = $urandom_range(0, 4);
         case (t)
            0: fr_wr($urandom_range(0, 255), $urandom_range(0, 255));
            1: fr_rd($urandom_range(0, 255));
            2: fr_alu($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            3: fr_dd($urandom_range(0, 255), $urandom_range(0, 255));
            default: begin
               op = $urandom_range(0, 255);
               while (op == 'hAA || op == 'hBB || op == 'hCC || op == 'hDD) op = $urandom_range(0, 255);
               exp_err++;
               send(op);
            end
         endcase
         wait_idle(300);
      end
      gap = 0; ff_rand = 0;

      rd_mute = 1;
      e0 = err_cnt;
      fr_rd(7);
      c = cyc;
`ifdef SYS_CTRL_TIMEOUT_EN
      exp_err++;
      begin
         int n = 0;
         while (!err && n < 40) begin @(negedge clk); n++; end
      end
      chk("t39_timeout_cycle", cyc - c, 16);
      chk("t39_busy", busy, 0);
      @(negedge clk);
`else
      repeat (40) @(negedge clk);
      chk("t39_still_busy", busy, 1);
      chk("t39_no_err", err_cnt - e0, 0);
      rst = 1'b0;
      @(negedge clk) rst = 1'b1;
`endif
      rd_mute = 0;
      repeat (3) @(negedge clk);

      chk("left_wr", exp_wr.size(), 0);
      chk("left_rd", exp_rd.size(), 0);
      chk("left_tx", exp_tx.size(), 0);
      chk("err_total", err_cnt, exp_err);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
